// File: rtl/magnitude_pkg.sv
// Shared constants and helpers for the magnitude (I*I + Q*Q) datapath.
package magnitude_pkg;

    localparam int PIPE_LATENCY = 2;

    // Sum of two full-precision squares needs one carry bit above 2*DATA_SIZE.
    function automatic int out_width(input int data_size);
        return 2 * data_size + 1;
    endfunction

endpackage

// File: rtl/magnitude_square.sv
// Registered square of one operand; sign-aware by parameter, captured only on en_i.
module magnitude_square
    import magnitude_pkg::*;
#(
    parameter int SIGNED    = 0,
    parameter int DATA_SIZE = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic [DATA_SIZE-1:0]   data_i,
    output logic [2*DATA_SIZE-1:0] sq_o
);

    logic                   fill;
    logic [2*DATA_SIZE-1:0] ext;
    logic [2*DATA_SIZE-1:0] sq_d;
    logic [2*DATA_SIZE-1:0] sq_q;

    // The low 2*DATA_SIZE bits of the extended product are the exact square in both modes.
    assign fill = (SIGNED != 0) & data_i[DATA_SIZE-1];
    assign ext  = {{DATA_SIZE{fill}}, data_i};

    always_comb begin
        sq_d = sq_q;
        if (en_i) begin
            sq_d = ext * ext;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_o = sq_q;

endmodule

// File: rtl/magnitude.sv
// Squared magnitude I*I + Q*Q: stage 1 squares each component, stage 2 sums and drives outputs.
module magnitude
    import magnitude_pkg::*;
#(
    parameter int SIGN_CORRECTION = 0,
    parameter int DATA_SIZE       = 16,
    localparam int OW             = out_width(DATA_SIZE)
) (
    input  logic                 data_clk_i,
    input  logic                 data_rst_i,
    input  logic [DATA_SIZE-1:0] data_i_i,
    input  logic [DATA_SIZE-1:0] data_q_i,
    input  logic                 data_en_i,
    input  logic                 data_sof_i,
    input  logic                 data_eof_i,
    output logic [OW-1:0]        data_o,
    output logic                 data_en_o,
    output logic                 data_sof_o,
    output logic                 data_eof_o
);

    logic [2*DATA_SIZE-1:0] sq_i;
    logic [2*DATA_SIZE-1:0] sq_q;
    logic [PIPE_LATENCY-1:0] en_q, en_d;
    logic [PIPE_LATENCY-1:0] sof_q, sof_d;
    logic [PIPE_LATENCY-1:0] eof_q, eof_d;
    logic [OW-1:0] sum_q, sum_d;

    magnitude_square #(
        .SIGNED    (SIGN_CORRECTION),
        .DATA_SIZE (DATA_SIZE)
    ) u_square_i (
        .clk_i   (data_clk_i),
        .rst_n_i (data_rst_i),
        .en_i    (data_en_i),
        .data_i  (data_i_i),
        .sq_o    (sq_i)
    );

    magnitude_square #(
        .SIGNED    (SIGN_CORRECTION),
        .DATA_SIZE (DATA_SIZE)
    ) u_square_q (
        .clk_i   (data_clk_i),
        .rst_n_i (data_rst_i),
        .en_i    (data_en_i),
        .data_i  (data_q_i),
        .sq_o    (sq_q)
    );

    // Frame markers only count when qualified by a valid sample.
    always_comb begin
        en_d  = {en_q[PIPE_LATENCY-2:0], data_en_i};
        sof_d = {sof_q[PIPE_LATENCY-2:0], data_sof_i & data_en_i};
        eof_d = {eof_q[PIPE_LATENCY-2:0], data_eof_i & data_en_i};
        sum_d = sum_q;
        if (en_q[0]) begin
            sum_d = {1'b0, sq_i} + {1'b0, sq_q};
        end
    end

    always_ff @(posedge data_clk_i or negedge data_rst_i) begin
        if (!data_rst_i) begin
            en_q  <= '0;
            sof_q <= '0;
            eof_q <= '0;
            sum_q <= '0;
        end else begin
            en_q  <= en_d;
            sof_q <= sof_d;
            eof_q <= eof_d;
            sum_q <= sum_d;
        end
    end

    assign data_o     = sum_q;
    assign data_en_o  = en_q[PIPE_LATENCY-1];
    assign data_sof_o = sof_q[PIPE_LATENCY-1];
    assign data_eof_o = eof_q[PIPE_LATENCY-1];

endmodule

// File: tb/tb_magnitude.sv
// Directed bench: unsigned and signed 10-bit instances driven from shared stimulus.
module tb_magnitude;

    localparam int DS = 10;
    localparam int OW = 2 * DS + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DS-1:0] di, dq;
    logic          en, sof, eof;

    logic [OW-1:0] u_data, s_data;
    logic          u_en, u_sof, u_eof;
    logic          s_en, s_sof, s_eof;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    magnitude #(.SIGN_CORRECTION(0), .DATA_SIZE(DS)) dut_u (
        .data_clk_i (clk),
        .data_rst_i (rst_n),
        .data_i_i   (di),
        .data_q_i   (dq),
        .data_en_i  (en),
        .data_sof_i (sof),
        .data_eof_i (eof),
        .data_o     (u_data),
        .data_en_o  (u_en),
        .data_sof_o (u_sof),
        .data_eof_o (u_eof)
    );

    magnitude #(.SIGN_CORRECTION(1), .DATA_SIZE(DS)) dut_s (
        .data_clk_i (clk),
        .data_rst_i (rst_n),
        .data_i_i   (di),
        .data_q_i   (dq),
        .data_en_i  (en),
        .data_sof_i (sof),
        .data_eof_i (eof),
        .data_o     (s_data),
        .data_en_o  (s_en),
        .data_sof_o (s_sof),
        .data_eof_o (s_eof)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive on the falling edge; outputs seen here reflect inputs from two steps earlier.
    task automatic step(input logic e, input logic [DS-1:0] i, input logic [DS-1:0] q,
                        input logic s, input logic f);
        @(negedge clk);
        en  = e;
        di  = i;
        dq  = q;
        sof = s;
        eof = f;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic chk_ctrl(input string tag, input logic e, input logic s, input logic f);
        chk({tag, "_u_en"},  64'(u_en),  64'(e));
        chk({tag, "_s_en"},  64'(s_en),  64'(e));
        chk({tag, "_u_sof"}, 64'(u_sof), 64'(s));
        chk({tag, "_s_sof"}, 64'(s_sof), 64'(s));
        chk({tag, "_u_eof"}, 64'(u_eof), 64'(f));
        chk({tag, "_s_eof"}, 64'(s_eof), 64'(f));
    endtask

    task automatic chk_data(input string tag, input logic [63:0] exp_u, input logic [63:0] exp_s);
        chk({tag, "_u_data"}, 64'(u_data), exp_u);
        chk({tag, "_s_data"}, 64'(s_data), exp_s);
    endtask

    logic [DS-1:0] vi  [4] = '{10'd1, 10'd2, 10'd0, 10'd7};
    logic [DS-1:0] vq  [4] = '{10'd1, 10'd0, 10'd5, 10'd7};
    logic [63:0]   vex [4] = '{64'd2, 64'd4, 64'd25, 64'd98};

    initial begin
        rst_n = 1'b0;
        en = 1'b1; di = 10'd9; dq = 10'd9; sof = 1'b1; eof = 1'b1;
        repeat (3) @(negedge clk);
        chk_ctrl("reset", 1'b0, 1'b0, 1'b0);
        chk_data("reset", 64'd0, 64'd0);
        en = 1'b0; sof = 1'b0; eof = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single sample 3,4 -> 25, exactly two cycles later, one-cycle pulse
        step(1'b1, 10'd3, 10'd4, 1'b0, 1'b0);
        idle();
        chk_ctrl("lat1", 1'b0, 1'b0, 1'b0);
        idle();
        chk_ctrl("lat2", 1'b1, 1'b0, 1'b0);
        chk_data("lat2", 64'd25, 64'd25);
        idle();
        chk_ctrl("pulse", 1'b0, 1'b0, 1'b0);
        chk_data("hold", 64'd25, 64'd25);

        // Values with en low must not disturb the held output
        step(1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0);
        step(1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0);
        step(1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0);
        chk_ctrl("noen", 1'b0, 1'b0, 1'b0);
        chk_data("noen", 64'd25, 64'd25);

        // All-ones: unsigned max vs signed -1
        step(1'b1, 10'h3FF, 10'h3FF, 1'b0, 1'b0);
        idle();
        idle();
        chk_ctrl("max", 1'b1, 1'b0, 1'b0);
        chk_data("max", 64'd2093058, 64'd2);

        // 0x200: signed case is the most negative value
        step(1'b1, 10'h200, 10'h200, 1'b0, 1'b0);
        idle();
        idle();
        chk_ctrl("minneg", 1'b1, 1'b0, 1'b0);
        chk_data("minneg", 64'd524288, 64'd524288);

        // Back-to-back frame with sof on first and eof on last
        for (int k = 0; k < 7; k++) begin
            if (k < 4) step(1'b1, vi[k], vq[k], k == 0, k == 3);
            else       idle();
            if (k >= 2) begin
                if (k - 2 < 4) begin
                    chk_ctrl($sformatf("b2b%0d", k - 2), 1'b1, (k - 2) == 0, (k - 2) == 3);
                    chk_data($sformatf("b2b%0d", k - 2), vex[k - 2], vex[k - 2]);
                end else begin
                    chk_ctrl("b2b_end", 1'b0, 1'b0, 1'b0);
                    chk_data("b2b_end", 64'd98, 64'd98);
                end
            end
        end

        // Markers without en are ignored
        step(1'b0, 10'd6, 10'd6, 1'b1, 1'b1);
        idle();
        chk_ctrl("sof_noen1", 1'b0, 1'b0, 1'b0);
        idle();
        chk_ctrl("sof_noen2", 1'b0, 1'b0, 1'b0);
        chk_data("sof_noen", 64'd98, 64'd98);

        // Reset one cycle after en: outputs clear at once, in-flight sample is dropped
        step(1'b1, 10'd5, 10'd5, 1'b1, 1'b1);
        @(negedge clk);
        en = 1'b0; sof = 1'b0; eof = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_ctrl("rst_async", 1'b0, 1'b0, 1'b0);
        chk_data("rst_async", 64'd0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle();
            chk_ctrl($sformatf("rst_drop%0d", k), 1'b0, 1'b0, 1'b0);
            chk_data($sformatf("rst_drop%0d", k), 64'd0, 64'd0);
        end

        // First sample after release, signed negative operand (-2, 3)
        step(1'b1, 10'h3FE, 10'd3, 1'b0, 1'b0);
        idle();
        chk_ctrl("post_rst1", 1'b0, 1'b0, 1'b0);
        idle();
        chk_ctrl("post_rst2", 1'b1, 1'b0, 1'b0);
        chk_data("post_rst2", 64'd1044493, 64'd13);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/magnitude.md
MAGNITUDE -- requirements
Module: magnitude

Interface
REQ-001 Parameter SIGN_CORRECTION, default 0: 0 = inputs unsigned; 1 = inputs two's-complement signed.
REQ-002 Parameter DATA_SIZE, default 16: width of each I/Q input; output width OW = 2*DATA_SIZE+1.
REQ-003 data_clk_i  in  1  single clock; all logic rising-edge.
REQ-004 data_rst_i  in  1  reset, asynchronous, active-low.
REQ-005 data_i_i  in  DATA_SIZE  in-phase sample.
REQ-006 data_q_i  in  DATA_SIZE  quadrature sample.
REQ-007 data_en_i  in  1  sample valid strobe.
REQ-008 data_sof_i  in  1  start-of-frame marker, meaningful only with data_en_i.
REQ-009 data_eof_i  in  1  end-of-frame marker, meaningful only with data_en_i.
REQ-010 data_o  out  OW  squared magnitude I*I + Q*Q, unsigned.
REQ-011 data_en_o  out  1  result valid strobe.
REQ-012 data_sof_o  out  1  sof aligned with data_en_o.
REQ-013 data_eof_o  out  1  eof aligned with data_en_o.

Function
REQ-014 data_o SHALL equal I*I + Q*Q, computed at full precision with no truncation or saturation.
REQ-015 SIGN_CORRECTION=0: I and Q SHALL be zero-extended; maximum result 2*(2^DATA_SIZE-1)^2 SHALL fit in OW bits.
REQ-016 SIGN_CORRECTION=1: I and Q SHALL be sign-extended; the most negative value -2^(DATA_SIZE-1) SHALL square correctly.
REQ-017 Pipeline: stage 1 registers I*I and Q*Q; stage 2 registers the sum and valid/sof/eof.
REQ-018 Latency SHALL be exactly 2 clock cycles from a sampled data_en_i=1 to data_en_o=1.
REQ-019 No back-pressure: the pipeline SHALL advance every cycle and accept data_en_i on consecutive cycles at full throughput.
REQ-020 data_en_o SHALL be a one-cycle pulse per accepted sample.
REQ-021 data_sof_o / data_eof_o SHALL equal data_sof_i / data_eof_i ANDed with data_en_i, delayed by 2 cycles.
REQ-022 data_o SHALL update only when a valid sample reaches stage 2 and SHALL hold its last value otherwise.
REQ-023 Input values presented with data_en_i=0 SHALL NOT affect data_o.

Reset
REQ-024 While data_rst_i=0, data_o, data_en_o, data_sof_o, data_eof_o and all pipeline registers SHALL be 0, asynchronously.
REQ-025 A sample in flight when reset asserts SHALL be discarded; no data_en_o for it after release.
REQ-026 The first sample accepted after reset release SHALL produce data_en_o 2 cycles later.

Structure
REQ-027 A shared package SHALL hold the output-width function (2*DATA_SIZE+1) and the pipeline latency constant (2).
REQ-028 One sub-module, magnitude_square, SHALL square one DATA_SIZE operand (sign-aware by parameter) with a registered 2*DATA_SIZE-bit output; magnitude instantiates two and adds.

Verification
REQ-029 Unsigned, I=3, Q=4, en=1 for one cycle -> 2 cycles later data_o=25, data_en_o=1 for one cycle.
REQ-030 DATA_SIZE=10, I=Q=0x3FF -> unsigned data_o=2093058; signed data_o=2.
REQ-031 DATA_SIZE=10, I=Q=0x200 -> both unsigned and signed data_o=524288 (signed checks -512 squaring).
REQ-032 Back-to-back en on 4 cycles with (1,1),(2,0),(0,5),(7,7) -> data_en_o on 4 consecutive cycles, data_o = 2, 4, 25, 98.
REQ-033 sof=1 with the first sample and eof=1 with the last sample of a frame -> data_sof_o/data_eof_o high on the matching data_en_o cycles only; sof=1 with en=0 -> no output.
REQ-034 Reset asserted one cycle after en=1 -> all outputs 0 immediately; no data_en_o after release.
